store_buffer: RTL and testbench

//  Posted-write FIFO between the EX/MEM pipeline register and the data memory write port.
//  - Accepts SB/SH/SW stores; aligns data to the word lane with byte enables.
//  - Drains one store per cycle when memory is ready.
//  - Checks every load address against pending stores, so younger loads never read stale data.

---
 rtl/rv_mem_pkg.sv | 48 ++++
 rtl/store_align.sv | 52 +++++
 rtl/store_buffer.sv | 149 ++++++++++++++
 tb/tb_store_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// ============================================================================
//  Module   : rv_mem_pkg
//  Purpose  : Shared funct3 encodings, store-buffer entry type and the
//             load byte-request helper for the data-memory write path.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_mem_pkg;

    localparam int RV_DM_ADDRESS = 9;
    localparam int RV_DATA_W     = 32;
    localparam int RV_BE_W       = RV_DATA_W / 8;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                       valid;
        logic [RV_DM_ADDRESS-3:0]   word_addr;
        logic [RV_BE_W-1:0]         be;
        logic [RV_DATA_W-1:0]       data;
    } sb_entry_t;

    // Byte lanes a load touches; unknown encodings conservatively claim the whole word
    function automatic logic [RV_BE_W-1:0] req_bytes(input logic [2:0] funct3,
                                                     input logic [1:0] addr);
        logic [RV_BE_W-1:0] be;
        case (funct3)
            F3_LB, F3_LBU: be = 4'b0001 << addr;
            F3_LH, F3_LHU: be = 4'b0011 << addr;
            F3_LW:         be = 4'b1111;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_align.sv
// ============================================================================
//  Module   : store_align
//  Purpose  : Combinational store aligner. Produces word-lane byte enables,
//             lane-replicated data and a misalignment / illegal-op flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module store_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]           st_addr_lo,
    input  logic [RV_DATA_W-1:0] st_data,
    input  logic [2:0]           st_funct3,
    output logic [RV_BE_W-1:0]   be,
    output logic [RV_DATA_W-1:0] data,
    output logic                 err
);

    // Replicate the significant bytes across the word so any lane picks them up
    always_comb begin
        be   = '0;
        data = '0;
        err  = 1'b0;
        case (st_funct3)
            F3_SB: begin
                be   = 4'b0001 << st_addr_lo;
                data = {4{st_data[7:0]}};
            end
            F3_SH: begin
                if (st_addr_lo[0]) begin
                    err = 1'b1;
                end else begin
                    be   = 4'b0011 << st_addr_lo;
                    data = {2{st_data[15:0]}};
                end
            end
            F3_SW: begin
                if (st_addr_lo != 2'b00) begin
                    err = 1'b1;
                end else begin
                    be   = 4'b1111;
                    data = st_data;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Posted-write FIFO between EX/MEM and the data-memory write port.
//             Aligns SB/SH/SW stores, drains one entry per cycle and checks
//             loads against pending stores (youngest first).
//  Config   : STORE_BUFFER_FWD_EN - forward fully covered loads from the
//             youngest overlapping entry instead of stalling.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module store_buffer
    import rv_mem_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DM_ADDRESS = RV_DM_ADDRESS,
    parameter int DATA_W     = RV_DATA_W
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    st_valid,
    input  logic [DM_ADDRESS-1:0]   st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  logic [2:0]              st_funct3,
    output logic                    st_ready,
    output logic                    st_err,
    input  logic                    ld_valid,
    input  logic [DM_ADDRESS-1:0]   ld_addr,
    input  logic [2:0]              ld_funct3,
    output logic                    ld_hit,
    output logic [DATA_W-1:0]       ld_fwd_data,
    output logic                    ld_stall,
    input  logic                    mem_ready,
    output logic                    mem_we,
    output logic [DM_ADDRESS-1:0]   mem_waddr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_be,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t              r_entries [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    logic [RV_BE_W-1:0]     w_align_be;
    logic [DATA_W-1:0]      w_align_data;
    logic                   w_align_err;
    logic                   w_accept;
    logic                   w_drain;
    logic [RV_BE_W-1:0]     w_req;
    logic                   w_found;
    sb_entry_t              w_head_ent;

    store_align u_align (
        .st_addr_lo (st_addr[1:0]),
        .st_data    (st_data),
        .st_funct3  (st_funct3),
        .be         (w_align_be),
        .data       (w_align_data),
        .err        (w_align_err)
    );

    // A full buffer refuses stores even when the head drains this cycle
    assign st_ready   = (r_count < CNT_W'(DEPTH));
    assign st_err     = st_valid && w_align_err;
    assign w_accept   = st_valid && st_ready && !w_align_err;
    assign w_drain    = (r_count != '0) && mem_ready;
    assign empty      = (r_count == '0);
    assign w_head_ent = r_entries[r_head];

    assign mem_we    = w_drain;
    assign mem_waddr = w_drain ? {w_head_ent.word_addr, 2'b00} : '0;
    assign mem_wdata = w_drain ? w_head_ent.data : '0;
    assign mem_be    = w_drain ? w_head_ent.be : '0;

    // Enqueue at tail, retire at head; count tracks the net change
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_entries[r_tail] <= '{valid:     1'b1,
                                       word_addr: st_addr[DM_ADDRESS-1:2],
                                       be:        w_align_be,
                                       data:      w_align_data};
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_entries[r_head].valid <= 1'b0;
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_accept, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_req = req_bytes(ld_funct3, ld_addr[1:0]);

`ifdef STORE_BUFFER_FWD_EN
    logic [RV_BE_W-1:0] w_sel_be;
    logic [DATA_W-1:0]  w_sel_data;
`endif

    // Scan from youngest (tail-1) to oldest; first overlapping valid entry wins
    always_comb begin
        w_found = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        w_sel_be   = '0;
        w_sel_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found
                && r_entries[r_tail - PTR_W'(i + 1)].valid
                && (r_entries[r_tail - PTR_W'(i + 1)].word_addr == ld_addr[DM_ADDRESS-1:2])
                && ((r_entries[r_tail - PTR_W'(i + 1)].be & w_req) != '0)) begin
                w_found = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                w_sel_be   = r_entries[r_tail - PTR_W'(i + 1)].be;
                w_sel_data = r_entries[r_tail - PTR_W'(i + 1)].data;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign ld_hit      = ld_valid && w_found && ((w_sel_be & w_req) == w_req);
    assign ld_stall    = ld_valid && w_found && ((w_sel_be & w_req) != w_req);
    assign ld_fwd_data = ld_hit ? w_sel_data : '0;
`else
    assign ld_hit      = 1'b0;
    assign ld_stall    = ld_valid && w_found;
    assign ld_fwd_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Directed, table-driven bench for store_buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
    localparam logic [2:0] LB = 3'b000, LW = 3'b010, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic [8:0]  st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_ready;
    logic        st_err;
    logic        ld_valid;
    logic [8:0]  ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_hit;
    logic [31:0] ld_fwd_data;
    logic        ld_stall;
    logic        mem_ready;
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_funct3   (st_funct3),
        .st_ready    (st_ready),
        .st_err      (st_err),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_funct3   (ld_funct3),
        .ld_hit      (ld_hit),
        .ld_fwd_data (ld_fwd_data),
        .ld_stall    (ld_stall),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .empty       (empty)
    );

    // ovl: 0 = no overlap, 1 = fully covered by youngest overlap, 2 = partial overlap
    typedef struct {
        string       name;
        logic        sv;
        logic [8:0]  sa;
        logic [31:0] sd;
        logic [2:0]  sf;
        logic        lv;
        logic [8:0]  la;
        logic [2:0]  lf;
        logic        mr;
        logic        rdy;
        logic        err;
        logic        we;
        logic [8:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        emp;
        int          ovl;
        logic [31:0] fwd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic sv, logic [8:0] sa, logic [31:0] sd,
                                logic [2:0] sf, logic lv, logic [8:0] la, logic [2:0] lf,
                                logic mr, logic rdy, logic err, logic we, logic [8:0] wa,
                                logic [31:0] wd, logic [3:0] be, logic emp, int ovl,
                                logic [31:0] fwd);
        vec_t v;
        v.name = n; v.sv = sv; v.sa = sa; v.sd = sd; v.sf = sf;
        v.lv = lv; v.la = la; v.lf = lf; v.mr = mr;
        v.rdy = rdy; v.err = err; v.we = we; v.wa = wa; v.wd = wd; v.be = be;
        v.emp = emp; v.ovl = ovl; v.fwd = fwd;
        return v;
    endfunction

    function automatic logic [82:0] expected(vec_t v);
        logic        hit;
        logic        stall;
        logic [31:0] f;
`ifdef STORE_BUFFER_FWD_EN
        hit   = (v.ovl == 1);
        stall = (v.ovl == 2);
        f     = hit ? v.fwd : 32'h0;
`else
        hit   = 1'b0;
        stall = (v.ovl != 0);
        f     = 32'h0;
`endif
        return {v.rdy, v.err, v.we, v.wa, v.wd, v.be, v.emp, hit, stall, f};
    endfunction

    function automatic logic [82:0] outs();
        return {st_ready, st_err, mem_we, mem_waddr, mem_wdata, mem_be, empty,
                ld_hit, ld_stall, ld_fwd_data};
    endfunction

    task automatic check(string name, logic [82:0] act, logic [82:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {rdy,err,we,waddr,wdata,be,empty,hit,stall,fwd}=%h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        st_valid  = v.sv;  st_addr = v.sa;  st_data   = v.sd; st_funct3 = v.sf;
        ld_valid  = v.lv;  ld_addr = v.la;  ld_funct3 = v.lf; mem_ready = v.mr;
        #1;
        check(v.name, outs(), expected(v));
    endtask

    task automatic idle_inputs(logic mr);
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; mem_ready = mr;
    endtask

    vec_t v_idle_e;
    vec_t rst_tbl[$];

    initial begin
        reset_n = 1'b0;
        idle_inputs(1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        v_idle_e = mk("reset", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("reset", outs(), expected(v_idle_e));
        reset_n = 1'b1;

        //        name          sv sa      sd            sf   lv la      lf   mr rdy err we wa      wd            be       emp ovl fwd
        tbl.push_back(mk("idle",      0, 9'h000, 32'h0,        SB,  0, 9'h000, LB,  1, 1, 0, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("sb_acc",    1, 9'h013, 32'h000000AB, SB,  0, 9'h000, LB,  1, 1, 0, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("sb_drain",  0, 9'h000, 32'h0,        SB,  0, 9'h000, LB,  1, 1, 0, 1, 9'h010, 32'hABABABAB, 4'b1000, 0, 0, 32'h0));
        tbl.push_back(mk("sh_misal",  1, 9'h021, 32'h00001234, SH,  0, 9'h000, LB,  1, 1, 1, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("f3_ill",    1, 9'h020, 32'h00001234, 3'b011, 0, 9'h000, LB, 1, 1, 1, 0, 9'h000, 32'h0,     4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("sw_040",    1, 9'h040, 32'h12345678, SW,  0, 9'h000, LB,  0, 1, 0, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("lw_fwd",    0, 9'h000, 32'h0,        SB,  1, 9'h040, LW,  0, 1, 0, 0, 9'h000, 32'h0,        4'h0,    0, 1, 32'h12345678));
        tbl.push_back(mk("sb_044",    1, 9'h044, 32'h000000CD, SB,  0, 9'h000, LB,  0, 1, 0, 0, 9'h000, 32'h0,        4'h0,    0, 0, 32'h0));
        tbl.push_back(mk("lw_part",   0, 9'h000, 32'h0,        SB,  1, 9'h044, LW,  0, 1, 0, 0, 9'h000, 32'h0,        4'h0,    0, 2, 32'h0));
        tbl.push_back(mk("conc",      1, 9'h048, 32'h11112222, SW,  1, 9'h080, LW,  1, 1, 0, 1, 9'h040, 32'h12345678, 4'hF,    0, 0, 32'h0));
        tbl.push_back(mk("lb_fwd",    0, 9'h000, 32'h0,        SB,  1, 9'h044, LB,  0, 1, 0, 0, 9'h000, 32'h0,        4'h0,    0, 1, 32'hCDCDCDCD));
        tbl.push_back(mk("lb_drain",  0, 9'h000, 32'h0,        SB,  1, 9'h044, LB,  1, 1, 0, 1, 9'h044, 32'hCDCDCDCD, 4'b0001, 0, 1, 32'hCDCDCDCD));
        tbl.push_back(mk("drain_048", 0, 9'h000, 32'h0,        SB,  0, 9'h000, LB,  1, 1, 0, 1, 9'h048, 32'h11112222, 4'hF,    0, 0, 32'h0));
        tbl.push_back(mk("empty1",    0, 9'h000, 32'h0,        SB,  0, 9'h000, LB,  1, 1, 0, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk($sformatf("fill%0d", i), 1, 9'h100 + 9'(4 * i), 32'hA0000001 + 32'(i), SW,
                             0, 9'h000, LB, 0, 1, 0, 0, 9'h000, 32'h0, 4'h0, (i == 0), 0, 32'h0));
        end
        tbl.push_back(mk("full",      1, 9'h110, 32'hBBBBBBBB, SW,  0, 9'h000, LB,  0, 0, 0, 0, 9'h000, 32'h0,        4'h0,    0, 0, 32'h0));
        tbl.push_back(mk("full_drain",1, 9'h110, 32'hBBBBBBBB, SW,  0, 9'h000, LB,  1, 0, 0, 1, 9'h100, 32'hA0000001, 4'hF,    0, 0, 32'h0));
        for (int i = 1; i < 4; i++) begin
            tbl.push_back(mk($sformatf("drain%0d", i), 0, 9'h000, 32'h0, SB, 0, 9'h000, LB, 1, 1, 0, 1,
                             9'h100 + 9'(4 * i), 32'hA0000001 + 32'(i), 4'hF, 0, 0, 32'h0));
        end
        tbl.push_back(mk("empty2",    0, 9'h000, 32'h0,        SB,  0, 9'h000, LB,  1, 1, 0, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("sw_misal",  1, 9'h042, 32'hDEADBEEF, SW,  0, 9'h000, LB,  1, 1, 1, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("sh_acc",    1, 9'h022, 32'h0000BEEF, SH,  0, 9'h000, LB,  0, 1, 0, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));
        tbl.push_back(mk("lhu_drain", 0, 9'h000, 32'h0,        SB,  1, 9'h022, LHU, 1, 1, 0, 1, 9'h020, 32'hBEEFBEEF, 4'b1100, 0, 1, 32'hBEEFBEEF));
        tbl.push_back(mk("empty3",    0, 9'h000, 32'h0,        SB,  0, 9'h000, LB,  1, 1, 0, 0, 9'h000, 32'h0,        4'h0,    1, 0, 32'h0));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while stores are pending must discard them
        rst_tbl.push_back(mk("pre_rst0", 1, 9'h060, 32'h55555555, SW, 0, 9'h000, LB, 0, 1, 0, 0, 9'h000, 32'h0, 4'h0, 1, 0, 32'h0));
        rst_tbl.push_back(mk("pre_rst1", 1, 9'h064, 32'h66666666, SW, 0, 9'h000, LB, 0, 1, 0, 0, 9'h000, 32'h0, 4'h0, 0, 0, 32'h0));
        foreach (rst_tbl[i]) apply(rst_tbl[i]);
        @(negedge clk);
        idle_inputs(1'b0);
        #1;
        check("pending2", {empty, st_ready}, {1'b0, 1'b1});
        reset_n = 1'b0;
        idle_inputs(1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_hold", outs(), expected(v_idle_e));
        reset_n = 1'b1;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 9'h060; ld_funct3 = LW;
        #1;
        check("rst_after", outs(), expected(v_idle_e));
        idle_inputs(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
